tri_setup: RTL

- Triangle setup stage directly upstream of the scanline fill logic.
- Once per frame it latches one packed 60-bit triangle and computes three edge-function coefficient sets, the doubled signed area, a winding flag, a degenerate flag and a screen bounding box.
- All outputs are registered and held stable for the consumer during the whole frame.
- Uses one shared multiplier pair, stepped by a small state machine.

---
 rtl/tri_setup_if.sv | 32 +++
 rtl/tri_setup.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tri_setup_if.sv
// Geometry request and result bundle between the frame controller (master)
// and the triangle setup stage (slave).
interface tri_setup_if #(
    parameter int COORD_W = 10
);
    logic                         start;
    logic [6*COORD_W-1:0]         geometry;
    logic                         busy;
    logic                         out_valid;
    logic [3*(COORD_W+1)-1:0]     edge_a;
    logic [3*(COORD_W+1)-1:0]     edge_b;
    logic [3*(2*COORD_W+2)-1:0]   edge_c;
    logic [2*COORD_W+2:0]         area2;
    logic                         flipped;
    logic                         degenerate;
    logic                         cull;
    logic [4*COORD_W-1:0]         bbox;

    // start is a one-cycle request; results are only meaningful while out_valid=1
    // and are held unchanged until the next accepted start.
    modport master (
        output start, geometry,
        input  busy, out_valid, edge_a, edge_b, edge_c, area2,
               flipped, degenerate, cull, bbox
    );

    modport slave (
        input  start, geometry,
        output busy, out_valid, edge_a, edge_b, edge_c, area2,
               flipped, degenerate, cull, bbox
    );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: edge coefficients, doubled area, winding and bbox, one edge per cycle.
// Optional macro TRI_SETUP_BACKFACE_CULL_EN also culls negatively wound triangles.
module tri_setup #(
    parameter int COORD_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    tri_setup_if.slave  bus,
    output logic [2:0]  dbg_state_o
);
    localparam int AW = COORD_W + 1;
    localparam int CW = 2*COORD_W + 2;
    localparam int SW = 2*COORD_W + 3;

    typedef enum logic [2:0] {IDLE, EDGE0, EDGE1, EDGE2, AREA, NORM, DONE} state_t;
    state_t state_q, state_d;

    logic                     start_q;
    logic [2:0][COORD_W-1:0]  x_q, y_q;
    logic [2:0][AW-1:0]       a_q, b_q;
    logic [2:0][CW-1:0]       c_q;
    logic [SW-1:0]            sum_q;
    logic                     neg_q;

    logic [3*AW-1:0]          edge_a_q, edge_b_q;
    logic [3*CW-1:0]          edge_c_q;
    logic [SW-1:0]            area2_q;
    logic                     out_valid_q, flipped_q, degenerate_q, cull_q;
    logic [4*COORD_W-1:0]     bbox_q;

    logic                     idle_like, accept;
    logic [1:0]               ei, ej;
    logic [COORD_W-1:0]       xi, yi, xj, yj;
    logic [2*COORD_W-1:0]     prod_a, prod_b;
    logic [AW-1:0]            a_new, b_new;
    logic [CW-1:0]            c_new;
    logic [SW-1:0]            sum_new;
    logic [COORD_W-1:0]       xmin, xmax, ymin, ymax;

    // start and geometry are sampled together; the FSM leaves IDLE/DONE one cycle later
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign accept    = idle_like && bus.start && !start_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_q) state_d = EDGE0;
            EDGE0:      state_d = EDGE1;
            EDGE1:      state_d = EDGE2;
            EDGE2:      state_d = AREA;
            AREA:       state_d = NORM;
            NORM:       state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // One shared multiplier pair serves edge i = vertex i -> vertex (i+1) mod 3
    always_comb begin
        case (state_q)
            EDGE1:   ei = 2'd1;
            EDGE2:   ei = 2'd2;
            default: ei = 2'd0;
        endcase
        ej      = (ei == 2'd2) ? 2'd0 : ei + 2'd1;
        xi      = x_q[ei];
        yi      = y_q[ei];
        xj      = x_q[ej];
        yj      = y_q[ej];
        prod_a  = {{COORD_W{1'b0}}, xi} * {{COORD_W{1'b0}}, yj};
        prod_b  = {{COORD_W{1'b0}}, xj} * {{COORD_W{1'b0}}, yi};
        a_new   = {1'b0, yi} - {1'b0, yj};
        b_new   = {1'b0, xj} - {1'b0, xi};
        c_new   = {2'b00, prod_a} - {2'b00, prod_b};
        sum_new = {c_q[0][CW-1], c_q[0]} + {c_q[1][CW-1], c_q[1]} + {c_q[2][CW-1], c_q[2]};
        xmin = x_q[0];
        xmax = x_q[0];
        ymin = y_q[0];
        ymax = y_q[0];
        for (int v = 1; v < 3; v++) begin
            if (x_q[v] < xmin) xmin = x_q[v];
            if (x_q[v] > xmax) xmax = x_q[v];
            if (y_q[v] < ymin) ymin = y_q[v];
            if (y_q[v] > ymax) ymax = y_q[v];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            sum_q        <= '0;
            neg_q        <= 1'b0;
            edge_a_q     <= '0;
            edge_b_q     <= '0;
            edge_c_q     <= '0;
            area2_q      <= '0;
            out_valid_q  <= 1'b0;
            flipped_q    <= 1'b0;
            degenerate_q <= 1'b0;
            cull_q       <= 1'b0;
            bbox_q       <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                for (int v = 0; v < 3; v++) begin
                    x_q[v] <= bus.geometry[(6-2*v)*COORD_W-1 -: COORD_W];
                    y_q[v] <= bus.geometry[(5-2*v)*COORD_W-1 -: COORD_W];
                end
                out_valid_q <= 1'b0;
            end
            case (state_q)
                EDGE0, EDGE1, EDGE2: begin
                    a_q[ei] <= a_new;
                    b_q[ei] <= b_new;
                    c_q[ei] <= c_new;
                end
                AREA: begin
                    sum_q <= sum_new;
                    neg_q <= sum_new[SW-1];
                end
                NORM: begin
                    // A zero area has a clear sign bit, so degenerate triangles stay un-negated
                    for (int i = 0; i < 3; i++) begin
                        edge_a_q[(3-i)*AW-1 -: AW] <= neg_q ? -a_q[i] : a_q[i];
                        edge_b_q[(3-i)*AW-1 -: AW] <= neg_q ? -b_q[i] : b_q[i];
                        edge_c_q[(3-i)*CW-1 -: CW] <= neg_q ? -c_q[i] : c_q[i];
                    end
                    area2_q      <= neg_q ? -sum_q : sum_q;
                    flipped_q    <= neg_q;
                    degenerate_q <= (sum_q == '0);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
                    cull_q       <= (sum_q == '0) || neg_q;
`else
                    cull_q       <= (sum_q == '0);
`endif
                    bbox_q       <= {xmin, xmax, ymin, ymax};
                    out_valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q == EDGE0) || (state_q == EDGE1) || (state_q == EDGE2) ||
                            (state_q == AREA)  || (state_q == NORM);
    assign bus.out_valid  = out_valid_q;
    assign bus.edge_a     = edge_a_q;
    assign bus.edge_b     = edge_b_q;
    assign bus.edge_c     = edge_c_q;
    assign bus.area2      = area2_q;
    assign bus.flipped    = flipped_q;
    assign bus.degenerate = degenerate_q;
    assign bus.cull       = cull_q;
    assign bus.bbox       = bbox_q;
    assign dbg_state_o    = state_q;
endmodule
